// File: rtl/eval_sequencer.sv
// ---------------------------------------------------------------------------
// eval_sequencer
//
// Issuing side of the evaluator handshake. Takes one position at a time
// from the search pipeline, starts the evaluator, waits for its result,
// blends the middlegame/endgame scores by game phase, flips the sign for
// black to move, and hands the score back over a valid/ready channel.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          position offer / accept (accept in IDLE only)
//   in_board, in_white_to_move,
//   in_phase                   position payload; phase is 0..256, clamped
//   board_valid                one-cycle evaluator start pulse
//   board, white_to_move       registered position driven to the evaluator
//   clear_eval                 one-cycle pulse releasing evaluator eval_valid
//   eval_mg, eval_eg,
//   eval_valid,
//   insufficient_material      evaluator result (level until clear_eval)
//   out_valid/out_ready        result handshake
//   out_score                  tapered, side-to-move relative score
//   out_insufficient           copy of the evaluator draw flag
//   timeout_err                sticky evaluator timeout flag
//
// Optional feature (macro EVAL_SEQ_STATS_EN):
//   stat_evals                 saturating count of completed result handshakes
//   stat_max_wait              saturating maximum WAIT length in cycles
// ---------------------------------------------------------------------------

`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

module eval_sequencer #(
   parameter int EVAL_WIDTH     = 32,
   parameter int PHASE_WIDTH    = 9,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [`BOARD_WIDTH-1:0]       in_board,
   input  logic                          in_white_to_move,
   input  logic [PHASE_WIDTH-1:0]        in_phase,
   output logic                          board_valid,
   output logic [`BOARD_WIDTH-1:0]       board,
   output logic                          white_to_move,
   output logic                          clear_eval,
   input  logic signed [EVAL_WIDTH-1:0]  eval_mg,
   input  logic signed [EVAL_WIDTH-1:0]  eval_eg,
   input  logic                          eval_valid,
   input  logic                          insufficient_material,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [EVAL_WIDTH-1:0]  out_score,
   output logic                          out_insufficient,
   output logic                          timeout_err
`ifdef EVAL_SEQ_STATS_EN
   ,
   output logic [31:0]                   stat_evals,
   output logic [15:0]                   stat_max_wait
`endif
);

   localparam int PROD_WIDTH = EVAL_WIDTH + PHASE_WIDTH + 1;
   localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PHASE_WIDTH-1:0] PHASE_FULL = PHASE_WIDTH'(256);
   localparam logic [CNT_WIDTH-1:0]   WAIT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_MUL,
      S_SCALE,
      S_OUT,
      S_CLEAR
   } state_t;

   state_t state;
   state_t next_state;

   logic [PHASE_WIDTH-1:0]        phase_q;
   logic [CNT_WIDTH-1:0]          wait_cnt;
   logic signed [EVAL_WIDTH-1:0]  cap_mg;
   logic signed [EVAL_WIDTH-1:0]  cap_eg;
   logic                          cap_ins;
   logic signed [PROD_WIDTH-1:0]  prod_a;
   logic signed [PROD_WIDTH-1:0]  prod_b;

   logic                          wait_expired;
   logic signed [PROD_WIDTH-1:0]  mg_ext;
   logic signed [PROD_WIDTH-1:0]  eg_ext;
   logic signed [PROD_WIDTH-1:0]  phase_ext;
   logic signed [PROD_WIDTH-1:0]  inv_phase_ext;
   logic signed [PROD_WIDTH:0]    sum_ab;
   logic signed [EVAL_WIDTH-1:0]  tapered;
   logic signed [EVAL_WIDTH-1:0]  score_next;

   assign wait_expired = (wait_cnt == WAIT_LAST);

   // State register. Reset abandons any evaluation in flight; the evaluator
   // shares this reset, so no clear_eval is needed on the way back to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. WAIT leaves on a result or after TIMEOUT_CYCLES
   // cycles without one; OUT waits for the consumer to take the score.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (in_valid) next_state = S_ISSUE;
         S_ISSUE: next_state = S_WAIT;
         S_WAIT:  if (eval_valid || wait_expired) next_state = S_MUL;
         S_MUL:   next_state = S_SCALE;
         S_SCALE: next_state = S_OUT;
         S_OUT:   if (out_ready) next_state = S_CLEAR;
         S_CLEAR: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Handshake outputs are pure state decodes. in_ready is also held low
   // while reset is asserted so nothing is offered-and-lost in that cycle.
   always_comb begin
      in_ready    = (state == S_IDLE) && !reset;
      board_valid = (state == S_ISSUE);
      clear_eval  = (state == S_CLEAR);
      out_valid   = (state == S_OUT);
   end

   // Taper arithmetic. Phase is unsigned, so it is zero-extended before the
   // signed multiply; the score operands are sign-extended.
   always_comb begin
      mg_ext        = PROD_WIDTH'(cap_mg);
      eg_ext        = PROD_WIDTH'(cap_eg);
      phase_ext     = $signed(PROD_WIDTH'(phase_q));
      inv_phase_ext = $signed(PROD_WIDTH'(PHASE_FULL - phase_q));
      sum_ab        = (PROD_WIDTH + 1)'(prod_a) + (PROD_WIDTH + 1)'(prod_b);
      tapered       = EVAL_WIDTH'(sum_ab >>> 8);
      score_next    = white_to_move ? tapered : -tapered;
      if (cap_ins) begin
         score_next = '0;
      end
   end

   // Datapath registers: position latch, WAIT counter, result capture,
   // the two partial products and the final score.
   always_ff @(posedge clk) begin
      if (reset) begin
         board            <= '0;
         white_to_move    <= 1'b0;
         phase_q          <= '0;
         wait_cnt         <= '0;
         cap_mg           <= '0;
         cap_eg           <= '0;
         cap_ins          <= 1'b0;
         prod_a           <= '0;
         prod_b           <= '0;
         out_score        <= '0;
         out_insufficient <= 1'b0;
         timeout_err      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               wait_cnt <= '0;
               if (in_valid) begin
                  board         <= in_board;
                  white_to_move <= in_white_to_move;
                  phase_q       <= (in_phase > PHASE_FULL) ? PHASE_FULL : in_phase;
               end
            end
            S_WAIT: begin
               if (eval_valid) begin
                  cap_mg  <= eval_mg;
                  cap_eg  <= eval_eg;
                  cap_ins <= insufficient_material;
               end else if (wait_expired) begin
                  timeout_err <= 1'b1;
                  cap_mg      <= '0;
                  cap_eg      <= '0;
                  cap_ins     <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_MUL: begin
               prod_a <= mg_ext * phase_ext;
               prod_b <= eg_ext * inv_phase_ext;
            end
            S_SCALE: begin
               out_score        <= score_next;
               out_insufficient <= cap_ins;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef EVAL_SEQ_STATS_EN
   logic [31:0] wait_len;
   logic [15:0] wait_len_sat;

   // Length of the WAIT phase that is ending now, saturated to 16 bits.
   always_comb begin
      wait_len     = 32'(wait_cnt) + 32'd1;
      wait_len_sat = (wait_len > 32'h0000_FFFF) ? 16'hFFFF : wait_len[15:0];
   end

   // Saturating statistics, sampled on the result handshake and on exit
   // from WAIT respectively.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_evals    <= '0;
         stat_max_wait <= '0;
      end else begin
         if ((state == S_OUT) && out_ready && (stat_evals != '1)) begin
            stat_evals <= stat_evals + 32'd1;
         end
         if ((state == S_WAIT) && (next_state == S_MUL) && (wait_len_sat > stat_max_wait)) begin
            stat_max_wait <= wait_len_sat;
         end
      end
   end
`endif

endmodule

// File: tb/tb_eval_sequencer.sv
// ---------------------------------------------------------------------------
// tb_eval_sequencer
//
// Directed bench for eval_sequencer. A small evaluator model answers each
// board_valid pulse after a chosen latency and holds eval_valid until
// clear_eval. A table of positions with hand-computed scores is run in a
// loop; backpressure, timeout and reset-in-WAIT are hand-written sequences.
// Stats ports are checked when EVAL_SEQ_STATS_EN is defined.
// ---------------------------------------------------------------------------

`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

module tb_eval_sequencer;

   localparam int EW = 32;
   localparam int PW = 9;
   localparam int TO = 64;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    in_valid;
   logic                    in_ready;
   logic [`BOARD_WIDTH-1:0] in_board;
   logic                    in_white_to_move;
   logic [PW-1:0]           in_phase;
   logic                    board_valid;
   logic [`BOARD_WIDTH-1:0] board;
   logic                    white_to_move;
   logic                    clear_eval;
   logic signed [EW-1:0]    eval_mg;
   logic signed [EW-1:0]    eval_eg;
   logic                    eval_valid;
   logic                    insufficient_material;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [EW-1:0]    out_score;
   logic                    out_insufficient;
   logic                    timeout_err;
`ifdef EVAL_SEQ_STATS_EN
   logic [31:0]             stat_evals;
   logic [15:0]             stat_max_wait;
`endif

   always #5 clk = ~clk;

   eval_sequencer #(
      .EVAL_WIDTH(EW),
      .PHASE_WIDTH(PW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_board(in_board),
      .in_white_to_move(in_white_to_move),
      .in_phase(in_phase),
      .board_valid(board_valid),
      .board(board),
      .white_to_move(white_to_move),
      .clear_eval(clear_eval),
      .eval_mg(eval_mg),
      .eval_eg(eval_eg),
      .eval_valid(eval_valid),
      .insufficient_material(insufficient_material),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_score(out_score),
      .out_insufficient(out_insufficient),
      .timeout_err(timeout_err)
`ifdef EVAL_SEQ_STATS_EN
      ,
      .stat_evals(stat_evals),
      .stat_max_wait(stat_max_wait)
`endif
   );

   // Evaluator model: eval_valid rises ev_lat cycles after the board_valid
   // cycle (never, if ev_never) and stays up until clear_eval.
   int ev_lat   = 7;
   bit ev_never = 1'b0;
   int ev_cnt;
   bit ev_busy;

   always @(posedge clk) begin
      if (reset) begin
         eval_valid <= 1'b0;
         ev_busy    <= 1'b0;
         ev_cnt     <= 0;
      end else if (clear_eval) begin
         eval_valid <= 1'b0;
         ev_busy    <= 1'b0;
      end else if (board_valid) begin
         ev_busy <= 1'b1;
         ev_cnt  <= 1;
         if (ev_lat <= 1 && !ev_never) eval_valid <= 1'b1;
      end else if (ev_busy && !eval_valid && !ev_never) begin
         ev_cnt <= ev_cnt + 1;
         if (ev_cnt + 1 >= ev_lat) eval_valid <= 1'b1;
      end
   end

   // Pulse counters, sampled mid-cycle.
   int bv_cnt = 0;
   int ce_cnt = 0;
   always @(negedge clk) begin
      if (board_valid) bv_cnt++;
      if (clear_eval)  ce_cnt++;
   end

   typedef struct {
      logic signed [EW-1:0] mg;
      logic signed [EW-1:0] eg;
      logic [PW-1:0]        phase;
      logic                 wtm;
      logic                 ins;
      int                   lat;
      bit                   early_ready;
      longint               exp_score;
      logic                 exp_ins;
   } vec_t;

   int compared   = 0;
   int mismatched = 0;

   logic [`BOARD_WIDTH-1:0] exp_board;
   int bv_snap;
   int ce_snap;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic logic [`BOARD_WIDTH-1:0] randomBoard();
      logic [`BOARD_WIDTH-1:0] b;
      for (int i = 0; i < `BOARD_WIDTH; i++) b[i] = 1'($urandom_range(0, 1));
      return b;
   endfunction

   // Offers one position (entered at a negedge) and waits for out_valid.
   task automatic applyStimulus(input vec_t v, output bit got_out);
      int guard;
      eval_mg               = v.mg;
      eval_eg               = v.eg;
      insufficient_material = v.ins;
      ev_lat                = v.lat;
      ev_never              = 1'b0;
      exp_board             = randomBoard();
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      in_board         = exp_board;
      in_white_to_move = v.wtm;
      in_phase         = v.phase;
      in_valid         = 1'b1;
      bv_snap          = bv_cnt;
      @(negedge clk);
      in_valid         = 1'b0;
      in_board         = ~exp_board;
      in_white_to_move = ~v.wtm;
      in_phase         = '0;
      if (v.early_ready) out_ready = 1'b1;
      guard = 0;
      while (!out_valid && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      got_out = out_valid;
      if (!got_out) checkOutput("out_valid_timeout", 0, 1);
   endtask

   // Completes the result handshake and checks the single clear_eval pulse.
   task automatic finishHandshake();
      ce_snap   = ce_cnt;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("clear_eval_high", longint'(clear_eval), 1);
      checkOutput("in_ready_in_clear", longint'(in_ready), 0);
      @(negedge clk);
      checkOutput("clear_eval_once", longint'(ce_cnt - ce_snap), 1);
      checkOutput("in_ready_idle", longint'(in_ready), 1);
   endtask

   vec_t vecs[9];

   initial begin
      bit got;
      int n;
      bit stable;
      logic signed [EW-1:0] held_score;
      logic [`BOARD_WIDTH-1:0] second_board;

      //             mg     eg     ph   wtm  ins lat er   score  ins
      vecs[0] = '{  100,   200,  256, 1, 0, 7, 0,   100, 0};
      vecs[1] = '{  100,   300,  128, 0, 0, 7, 0,  -200, 0};
      vecs[2] = '{  100,   300,    0, 0, 0, 7, 0,  -300, 0};
      vecs[3] = '{  500,   500,  256, 1, 1, 4, 0,     0, 1};
      vecs[4] = '{   -1,     0,  128, 1, 0, 2, 0,    -1, 0};
      vecs[5] = '{   50,   -70,  300, 1, 0, 5, 0,    50, 0};
      vecs[6] = '{   -3,     5,    1, 0, 0, 3, 0,    -4, 0};
      vecs[7] = '{    0,    -1,    1, 1, 0, 1, 1,    -1, 0};
      vecs[8] = '{-1000, -1000,  200, 0, 0, 3, 0,  1000, 0};

      reset = 1'b1;
      in_valid = 1'b0;
      in_board = '0;
      in_white_to_move = 1'b0;
      in_phase = '0;
      eval_mg = '0;
      eval_eg = '0;
      insufficient_material = 1'b0;
      out_ready = 1'b0;

      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_in_ready", longint'(in_ready), 0);
      checkOutput("reset_board_valid", longint'(board_valid), 0);
      checkOutput("reset_out_valid", longint'(out_valid), 0);
      checkOutput("reset_out_score", longint'(out_score), 0);
      checkOutput("reset_timeout_err", longint'(timeout_err), 0);
      checkOutput("reset_board_zero", longint'(board == '0), 1);
`ifdef EVAL_SEQ_STATS_EN
      checkOutput("reset_stat_evals", longint'(stat_evals), 0);
      checkOutput("reset_stat_max_wait", longint'(stat_max_wait), 0);
`endif
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_in_ready", longint'(in_ready), 1);

      // Table-driven positions.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i], got);
         if (got) begin
            checkOutput($sformatf("v%0d_score", i), longint'(out_score), vecs[i].exp_score);
            checkOutput($sformatf("v%0d_ins", i), longint'(out_insufficient), longint'(vecs[i].exp_ins));
            checkOutput($sformatf("v%0d_board_held", i), longint'(board == exp_board), 1);
            checkOutput($sformatf("v%0d_wtm", i), longint'(white_to_move), longint'(vecs[i].wtm));
            checkOutput($sformatf("v%0d_board_valid_once", i), longint'(bv_cnt - bv_snap), 1);
            checkOutput($sformatf("v%0d_no_timeout", i), longint'(timeout_err), 0);
            finishHandshake();
         end
      end

      // Backpressure: result held for 10 cycles, second offer blocked.
      applyStimulus(vecs[0], got);
      if (got) begin
         held_score   = out_score;
         second_board = randomBoard();
         in_board     = second_board;
         in_white_to_move = 1'b0;
         in_phase     = 9'd128;
         in_valid     = 1'b1;
         stable       = 1'b1;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!out_valid || out_score != held_score || in_ready) stable = 1'b0;
         end
         checkOutput("bp_stable", longint'(stable), 1);
         checkOutput("bp_score", longint'(out_score), 100);
         eval_mg = 100;
         eval_eg = 300;
         insufficient_material = 1'b0;
         ev_lat  = 7;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         checkOutput("bp_clear", longint'(clear_eval), 1);
         checkOutput("bp_not_taken_in_clear", longint'(board == exp_board), 1);
         @(negedge clk);
         checkOutput("bp_ready_after_clear", longint'(in_ready), 1);
         @(negedge clk);
         in_valid = 1'b0;
         checkOutput("bp_second_issue", longint'(board_valid), 1);
         checkOutput("bp_second_board", longint'(board == second_board), 1);
         n = 0;
         while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
         end
         checkOutput("bp_second_score", longint'(out_score), -200);
         finishHandshake();
      end

      // Timeout: evaluator never answers.
      ev_never = 1'b1;
      eval_mg  = 100;
      eval_eg  = 100;
      in_board = randomBoard();
      in_white_to_move = 1'b1;
      in_phase = 9'd256;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!board_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!timeout_err && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("timeout_after_64_wait", longint'(n), 65);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("timeout_out_valid", longint'(out_valid), 1);
      checkOutput("timeout_score", longint'(out_score), 0);
      finishHandshake();
      checkOutput("timeout_sticky", longint'(timeout_err), 1);

      // Reset while in WAIT.
      ev_never = 1'b0;
      ev_lat   = 20;
      eval_mg  = 77;
      in_board = randomBoard();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      ce_snap = ce_cnt;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rw_in_ready", longint'(in_ready), 0);
      checkOutput("rw_board_valid", longint'(board_valid), 0);
      checkOutput("rw_clear_eval", longint'(clear_eval), 0);
      checkOutput("rw_out_valid", longint'(out_valid), 0);
      checkOutput("rw_out_score", longint'(out_score), 0);
      checkOutput("rw_out_ins", longint'(out_insufficient), 0);
      checkOutput("rw_timeout_err", longint'(timeout_err), 0);
      checkOutput("rw_board", longint'(board == '0), 1);
      checkOutput("rw_wtm", longint'(white_to_move), 0);
`ifdef EVAL_SEQ_STATS_EN
      checkOutput("rw_stat_evals", longint'(stat_evals), 0);
      checkOutput("rw_stat_max_wait", longint'(stat_max_wait), 0);
`endif
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rw_no_clear_eval", longint'(ce_cnt - ce_snap), 0);
      applyStimulus(vecs[1], got);
      if (got) begin
         checkOutput("rw_after_score", longint'(out_score), -200);
         finishHandshake();
      end
`ifdef EVAL_SEQ_STATS_EN
      checkOutput("stat_evals_one", longint'(stat_evals), 1);
      checkOutput("stat_max_wait_seven", longint'(stat_max_wait), 7);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got hang, expected completion");
      $fatal(1, "[TB] global timeout");
   end

endmodule
